bcp_pe_multi: RTL and testbench

Parametrised successor to the single-literal BCP processing element. It prunes each streamed clause against a set of up to NUM_UC concurrently applied unit literals. Each clause is classified as satisfied, conflicting, implying or unresolved, and surviving clauses are forwarded through a registered, back-pressured output stage. It sits between the clause queue (CLQ) and the engine push queue (ENG_P), and loads a new unit-literal set from the unit-clause queue (UCQ) at each round delimiter.

---
 rtl/bcp_pkg.sv | 48 ++++
 rtl/bcp_prune_core.sv | 70 +++++++
 rtl/bcp_pe_multi.sv | 138 +++++++++++++
 tb/tb_bcp_pe_multi.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcp_pkg.sv
// Shared types and helpers for the multi-literal BCP processing element.
package bcp_pkg;

   localparam int unsigned LIT_W   = 8;
   localparam int unsigned CLA_LEN = 3;
   localparam int unsigned NUM_UC  = 2;

   // Two's-complement literal; 0 marks an empty or pruned slot.
   typedef logic [LIT_W-1:0]    lit_t;
   typedef lit_t [CLA_LEN-1:0]  cla_t;
   typedef lit_t [NUM_UC-1:0]   uc_set_t;

   typedef enum logic [2:0] {
      RES_NONE,
      RES_SAT,
      RES_CONFLICT,
      RES_IMPLY,
      RES_DELIM
   } res_kind_t;

   typedef enum logic {
      WAIT_UC,
      RUN
   } state_t;

   typedef struct packed {
      cla_t clause;
      logic delim;
      logic conflict;
      logic imply;
      lit_t imply_lit;
   } out_pl_t;

   localparam lit_t LIT_MIN = {1'b1, {(LIT_W-1){1'b0}}};

   // True when the set holds some literal together with its negation.
   function automatic logic uc_self_conflict(input uc_set_t s);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_UC; i++) begin
         for (int j = 0; j < NUM_UC; j++) begin
            if (s[i] != '0 && s[i] == lit_t'(-s[j])) r = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcp_prune_core.sv
// Combinational pruning of one clause against the active unit-literal set.
module bcp_prune_core
   import bcp_pkg::*;
(
   input  logic [CLA_LEN*LIT_W-1:0] cla,
   input  logic [NUM_UC*LIT_W-1:0]  uc,
   output logic [CLA_LEN*LIT_W-1:0] pr,
   output res_kind_t                kind,
   output logic [LIT_W-1:0]         imply_lit
);

   cla_t    c;
   uc_set_t u;
   cla_t    p;
   logic    sat;
   logic    any_lit;
   logic    multi_lit;
   lit_t    first_lit;

   assign c  = cla;
   assign u  = uc;
   assign pr = p;

   // Match each slot against every nonzero unit literal and its negation.
   always_comb begin
      sat = 1'b0;
      p   = c;
      for (int i = 0; i < CLA_LEN; i++) begin
         for (int j = 0; j < NUM_UC; j++) begin
            if (u[j] != '0) begin
               if (c[i] == u[j]) sat = 1'b1;
               if (c[i] == lit_t'(-u[j])) p[i] = '0;
            end
         end
      end
   end

   // A survivor is unit when all nonzero slots carry the same literal.
   always_comb begin
      any_lit   = 1'b0;
      multi_lit = 1'b0;
      first_lit = '0;
      for (int i = 0; i < CLA_LEN; i++) begin
         if (p[i] != '0) begin
            if (!any_lit) begin
               any_lit   = 1'b1;
               first_lit = p[i];
            end else if (p[i] != first_lit) begin
               multi_lit = 1'b1;
            end
         end
      end
   end

   always_comb begin
      kind      = RES_NONE;
      imply_lit = '0;
      if (c == '0) begin
         kind = RES_DELIM;
      end else if (sat) begin
         kind = RES_SAT;
      end else if (!any_lit) begin
         kind = RES_CONFLICT;
      end else if (!multi_lit) begin
         kind      = RES_IMPLY;
         imply_lit = first_lit;
      end
   end

endmodule

// File: rtl/bcp_pe_multi.sv
// BCP processing element: applies a unit-literal set per round to streamed
// clauses and forwards survivors through a back-pressured output register.
module bcp_pe_multi
   import bcp_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     cla_valid,
   output logic                     cla_ready,
   input  logic [CLA_LEN*LIT_W-1:0] cla_in,
   input  logic                     uc_valid,
   output logic                     uc_ready,
   input  logic [NUM_UC*LIT_W-1:0]  uc_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CLA_LEN*LIT_W-1:0] out_clause,
   output logic                     out_delim,
   output logic                     out_conflict,
   output logic                     out_imply,
   output logic [LIT_W-1:0]         out_imply_lit,
   output logic                     conflict_sticky,
   output logic [CNT_W-1:0]         cnt_sat,
   output logic [CNT_W-1:0]         cnt_conflict,
   output logic [CNT_W-1:0]         cnt_imply
);

   state_t                   state;
   uc_set_t                  uc_q;
   out_pl_t                  out_q;
   logic                     out_v;
   logic [CLA_LEN*LIT_W-1:0] pr;
   res_kind_t                kind;
   logic [LIT_W-1:0]         imply_lit;
   logic                     uc_fire;
   logic                     cla_fire;
   logic                     emit;
   cla_t                     cla_v;
   uc_set_t                  uc_v;
   logic                     cla_bad;
   logic                     uc_bad;

   // Handshakes are suppressed entirely during a flush cycle.
   always_comb begin
      uc_ready  = 1'b0;
      cla_ready = 1'b0;
      if (!flush) begin
         uc_ready  = (state == WAIT_UC);
         cla_ready = (state == RUN) && (!out_v || out_ready);
      end
   end

   assign uc_fire  = uc_valid && uc_ready;
   assign cla_fire = cla_valid && cla_ready;
   assign emit     = cla_fire && (kind != RES_SAT);

   bcp_prune_core u_core (
      .cla       (cla_in),
      .uc        (uc_q),
      .pr        (pr),
      .kind      (kind),
      .imply_lit (imply_lit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= WAIT_UC;
         uc_q            <= '0;
         out_v           <= 1'b0;
         out_q           <= '0;
         conflict_sticky <= 1'b0;
         cnt_sat         <= '0;
         cnt_conflict    <= '0;
         cnt_imply       <= '0;
      end else if (flush) begin
         state           <= WAIT_UC;
         uc_q            <= '0;
         out_v           <= 1'b0;
         out_q           <= '0;
         conflict_sticky <= 1'b0;
      end else begin
         if (uc_fire) begin
            uc_q  <= uc_in;
            state <= RUN;
         end
         if (cla_fire && kind == RES_DELIM) state <= WAIT_UC;

         // Reload on accept, else drain when the consumer takes the result.
         if (emit) begin
            out_v <= 1'b1;
            out_q <= '{clause:    cla_t'(pr),
                       delim:     (kind == RES_DELIM),
                       conflict:  (kind == RES_CONFLICT),
                       imply:     (kind == RES_IMPLY),
                       imply_lit: lit_t'(imply_lit)};
         end else if (out_ready) begin
            out_v <= 1'b0;
            out_q <= '0;
         end

         if ((emit && kind == RES_CONFLICT) || (uc_fire && uc_self_conflict(uc_in)))
            conflict_sticky <= 1'b1;

         if (cla_fire && kind == RES_SAT && cnt_sat != '1)
            cnt_sat <= cnt_sat + CNT_W'(1);
         if (emit && kind == RES_CONFLICT && cnt_conflict != '1)
            cnt_conflict <= cnt_conflict + CNT_W'(1);
         if (emit && kind == RES_IMPLY && cnt_imply != '1)
            cnt_imply <= cnt_imply + CNT_W'(1);
      end
   end

   assign out_valid     = out_v;
   assign out_clause    = out_q.clause;
   assign out_delim     = out_q.delim;
   assign out_conflict  = out_q.conflict;
   assign out_imply     = out_q.imply;
   assign out_imply_lit = out_q.imply_lit;

   // The most negative literal has no negation and must never be presented.
   assign cla_v = cla_in;
   assign uc_v  = uc_in;

   always_comb begin
      cla_bad = 1'b0;
      uc_bad  = 1'b0;
      for (int i = 0; i < CLA_LEN; i++) if (cla_v[i] == LIT_MIN) cla_bad = 1'b1;
      for (int j = 0; j < NUM_UC; j++)  if (uc_v[j] == LIT_MIN)  uc_bad  = 1'b1;
   end

   a_cla_legal: assert property (@(posedge clk) disable iff (!rst_n)
                                 !(cla_fire && cla_bad));
   a_uc_legal:  assert property (@(posedge clk) disable iff (!rst_n)
                                 !(uc_fire && uc_bad));

endmodule

// File: tb/tb_bcp_pe_multi.sv
// Directed scoreboard bench for bcp_pe_multi.
module tb_bcp_pe_multi;
   import bcp_pkg::*;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned CW    = CLA_LEN*LIT_W;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic              cla_valid;
   logic              cla_ready;
   logic [CW-1:0]     cla_in;
   logic              uc_valid;
   logic              uc_ready;
   logic [NUM_UC*LIT_W-1:0] uc_in;
   logic              out_valid;
   logic              out_ready;
   logic [CW-1:0]     out_clause;
   logic              out_delim;
   logic              out_conflict;
   logic              out_imply;
   logic [LIT_W-1:0]  out_imply_lit;
   logic              conflict_sticky;
   logic [CNT_W-1:0]  cnt_sat;
   logic [CNT_W-1:0]  cnt_conflict;
   logic [CNT_W-1:0]  cnt_imply;

   int      checks = 0;
   int      errors = 0;
   out_pl_t exp_q[$];
   out_pl_t mon_act;
   out_pl_t mon_exp;

   bcp_pe_multi #(.CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (flush),
      .cla_valid       (cla_valid),
      .cla_ready       (cla_ready),
      .cla_in          (cla_in),
      .uc_valid        (uc_valid),
      .uc_ready        (uc_ready),
      .uc_in           (uc_in),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_clause      (out_clause),
      .out_delim       (out_delim),
      .out_conflict    (out_conflict),
      .out_imply       (out_imply),
      .out_imply_lit   (out_imply_lit),
      .conflict_sticky (conflict_sticky),
      .cnt_sat         (cnt_sat),
      .cnt_conflict    (cnt_conflict),
      .cnt_imply       (cnt_imply)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [CW-1:0] mk(input int a, input int b, input int c);
      return {LIT_W'(c), LIT_W'(b), LIT_W'(a)};
   endfunction

   function automatic out_pl_t ex(input logic [CW-1:0] c, input logic d, input logic cf,
                                  input logic im, input int lit);
      out_pl_t r;
      r.clause    = c;
      r.delim     = d;
      r.conflict  = cf;
      r.imply     = im;
      r.imply_lit = LIT_W'(lit);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic send_uc(input int a, input int b);
      bit done;
      done     = 1'b0;
      uc_in    = {LIT_W'(b), LIT_W'(a)};
      uc_valid = 1'b1;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         done = uc_ready;
         @(posedge clk);
         #1;
      end
      uc_valid = 1'b0;
      if (!done) chk("uc_handshake_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_cla(input logic [CW-1:0] c, input bit drop, input out_pl_t e);
      bit done;
      done = 1'b0;
      if (!drop) exp_q.push_back(e);
      cla_in    = c;
      cla_valid = 1'b1;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         done = cla_ready;
         @(posedge clk);
         #1;
      end
      cla_valid = 1'b0;
      if (!done) chk("cla_handshake_timeout", 32'd0, 32'd1);
   endtask

   // Scoreboard monitor: every transfer on the output port pops one expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         mon_act = {out_clause, out_delim, out_conflict, out_imply, out_imply_lit};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got %0h expected none", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               errors++;
               $display("FAIL out_payload: got %0h expected %0h", mon_act, mon_exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      cla_valid = 1'b0;
      cla_in    = '0;
      uc_valid  = 1'b0;
      uc_in     = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sticky", 32'(conflict_sticky), 32'd0);
      chk("rst_cnt_sat", 32'(cnt_sat), 32'd0);
      chk("rst_uc_ready", 32'(uc_ready), 32'd1);
      chk("rst_cla_ready", 32'(cla_ready), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Satisfied clause is dropped
      send_uc(3, 0);
      send_cla(mk(3, -5, 7), 1'b1, '0);
      @(negedge clk);
      chk("sat_no_out", 32'(out_valid), 32'd0);
      chk("sat_cnt", 32'(cnt_sat), 32'd1);
      @(posedge clk);
      #1;

      // Delimiter is forwarded and reopens the UC queue
      send_cla(mk(0, 0, 0), 1'b0, ex(mk(0, 0, 0), 1'b1, 1'b0, 1'b0, 0));
      @(negedge clk);
      chk("delim_flag", 32'(out_delim), 32'd1);
      chk("delim_uc_ready", 32'(uc_ready), 32'd1);
      @(posedge clk);
      #1;

      // Pruning to a unit clause and plain survivor
      send_uc(3, -7);
      send_cla(mk(-3, 7, 5), 1'b0, ex(mk(0, 0, 5), 1'b0, 1'b0, 1'b1, 5));
      send_cla(mk(1, 2, 4), 1'b0, ex(mk(1, 2, 4), 1'b0, 1'b0, 1'b0, 0));
      send_cla(mk(0, 0, 0), 1'b0, ex(mk(0, 0, 0), 1'b1, 1'b0, 1'b0, 0));

      // Conflict, duplicate-literal unit clause, satisfaction beating negation
      send_uc(2, 4);
      send_cla(mk(-2, -4, 0), 1'b0, ex(mk(0, 0, 0), 1'b0, 1'b1, 1'b0, 0));
      @(negedge clk);
      chk("conf_sticky", 32'(conflict_sticky), 32'd1);
      chk("conf_cnt", 32'(cnt_conflict), 32'd1);
      @(posedge clk);
      #1;
      send_cla(mk(-2, 9, 9), 1'b0, ex(mk(0, 9, 9), 1'b0, 1'b0, 1'b1, 9));
      send_cla(mk(-2, 4, 5), 1'b1, '0);
      @(negedge clk);
      chk("sat_wins_cnt", 32'(cnt_sat), 32'd2);
      @(posedge clk);
      #1;

      // Back-pressure: hold, then drain back-to-back
      out_ready = 1'b0;
      send_cla(mk(6, 7, 8), 1'b0, ex(mk(6, 7, 8), 1'b0, 1'b0, 1'b0, 0));
      cla_in    = mk(-2, 11, 12);
      cla_valid = 1'b1;
      exp_q.push_back(ex(mk(0, 11, 12), 1'b0, 1'b0, 1'b0, 0));
      repeat (3) begin
         @(negedge clk);
         chk("bp_cla_ready", 32'(cla_ready), 32'd0);
         chk("bp_hold_clause", 32'(out_clause), 32'(mk(6, 7, 8)));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 32'(cla_ready), 32'd1);
      @(posedge clk);
      #1;
      cla_in = mk(13, 0, 0);
      exp_q.push_back(ex(mk(13, 0, 0), 1'b0, 1'b0, 1'b1, 13));
      @(negedge clk);
      chk("b2b_valid_1", 32'(out_valid), 32'd1);
      chk("b2b_clause_1", 32'(out_clause), 32'(mk(0, 11, 12)));
      @(posedge clk);
      #1;
      cla_valid = 1'b0;
      @(negedge clk);
      chk("b2b_valid_2", 32'(out_valid), 32'd1);
      chk("b2b_imply_2", 32'(out_imply_lit), 32'd13);
      @(posedge clk);
      #1;

      // Flush while a result is pending
      out_ready = 1'b0;
      cla_in    = mk(20, 0, 0);
      cla_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      cla_valid = 1'b0;
      flush     = 1'b1;
      @(negedge clk);
      chk("flush_pending_valid", 32'(out_valid), 32'd1);
      chk("flush_cla_ready", 32'(cla_ready), 32'd0);
      chk("flush_uc_ready", 32'(uc_ready), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_wait_uc", 32'(uc_ready), 32'd1);
      chk("flush_sticky", 32'(conflict_sticky), 32'd0);
      chk("flush_cnt_sat", 32'(cnt_sat), 32'd2);
      chk("flush_cnt_conflict", 32'(cnt_conflict), 32'd1);
      chk("flush_cnt_imply", 32'(cnt_imply), 32'd4);
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      // Self-contradictory unit set raises the sticky flag
      send_uc(1, -1);
      @(negedge clk);
      chk("uc_contra_sticky", 32'(conflict_sticky), 32'd1);
      @(posedge clk);
      #1;

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      cla_in    = mk(30, 31, 0);
      cla_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      cla_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_clause", 32'(out_clause), 32'd0);
      chk("arst_sticky", 32'(conflict_sticky), 32'd0);
      chk("arst_cnt_imply", 32'(cnt_imply), 32'd0);
      chk("arst_cnt_sat", 32'(cnt_sat), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
